// File: rtl/dmem_pipelined.sv
// rtl/dmem_pipelined.sv - word-addressed data memory with latency pipeline and in-order response FIFO
// Responses (load data, store acks, faults) flow through READ_LATENCY stages into a FIFO sized to the credit limit.
module dmem_pipelined #(
  parameter int DEPTH_WORDS  = 16384,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byte_en,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_write,
  output logic        resp_fault
);
  localparam int FIFO_DEPTH = READ_LATENCY + 1;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic        write;
    logic        fault;
    logic [31:0] rdata;
  } resp_t;

  logic          accept;
  logic          consume;
  logic [31:0]   word_addr;
  logic [AW-1:0] word_idx;
  logic          range_fault;
  logic          lane_fault;
  logic          req_fault;
  logic          unused_addr_bits;

  logic          ready_en_q;
  logic [CW-1:0] out_q;
  logic [CW-1:0] out_d;

  assign word_addr        = {2'b00, req_addr[31:2]};
  assign word_idx         = req_addr[2 +: AW];
  assign unused_addr_bits = ^req_addr[1:0];
  assign range_fault      = (word_addr >= 32'(DEPTH_WORDS));

  always_comb begin
    lane_fault = req_write;
    case (req_byte_en)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: lane_fault = 1'b0;
      default:                   lane_fault = req_write;
    endcase
  end

  assign req_fault = range_fault | lane_fault;
  assign req_ready = ready_en_q && (out_q < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  // RAM is written and read at the accepting edge; contents survive reset.
  logic [31:0] ram_q [DEPTH_WORDS];
  logic [31:0] rd_word_q;

  always_ff @(posedge clock) begin
    if (accept && !req_fault) begin
      if (req_write) begin
        for (int b = 0; b < 4; b++) begin
          if (req_byte_en[b]) ram_q[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end else begin
        rd_word_q <= ram_q[word_idx];
      end
    end
  end

  logic [READ_LATENCY-1:0] pv_q;
  resp_t                   pd_q      [READ_LATENCY];
  resp_t                   stage_out [READ_LATENCY];

  // Stage 0 carries zero data; RAM read data is merged in for clean loads only.
  always_comb begin
    for (int k = 0; k < READ_LATENCY; k++) stage_out[k] = pd_q[k];
    if (!pd_q[0].write && !pd_q[0].fault) stage_out[0].rdata = rd_word_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= accept;
      for (int k = 1; k < READ_LATENCY; k++) pv_q[k] <= pv_q[k-1];
    end
  end

  always_ff @(posedge clock) begin
    pd_q[0] <= {req_write, req_fault, 32'd0};
    for (int k = 1; k < READ_LATENCY; k++) pd_q[k] <= stage_out[k-1];
  end

  resp_t         fifo_q [FIFO_DEPTH];
  resp_t         head;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push       = pv_q[READ_LATENCY-1];
  assign resp_valid = (cnt_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign consume    = pop;
  assign head       = fifo_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= stage_out[READ_LATENCY-1];
  end

  always_comb begin
    out_d = out_q;
    if (accept && !consume)      out_d = out_q + 1'b1;
    else if (!accept && consume) out_d = out_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      out_q      <= out_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign resp_rdata = resp_valid ? head.rdata : 32'd0;
  assign resp_write = resp_valid ? head.write : 1'b0;
  assign resp_fault = resp_valid ? head.fault : 1'b0;

endmodule

// File: tb/tb_dmem_pipelined.sv
// tb/tb_dmem_pipelined.sv - scoreboard bench for dmem_pipelined against a word-array reference model
module tb_dmem_pipelined;
  localparam int DEPTH = 16384;
  localparam int RL    = 3;
  localparam int FD    = RL + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_byte_en = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_write;
  logic        resp_fault;

  always #5 clock = ~clock;

  dmem_pipelined #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_byte_en(req_byte_en),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_write (resp_write),
    .resp_fault (resp_fault)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        write;
    logic        fault;
    int          acc_cyc;
    bit          exact;
    int          seq;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        head_e;
  logic [31:0] model_mem [DEPTH];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          seq_n = 0;
  int          last_seq = -1;
  int          acc_cnt = 0;
  int          cons_cnt = 0;
  bit          toggle_mode = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic bit lane_ok(input logic [3:0] be);
    return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  task automatic record_accept(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be, input bit exact);
    exp_t e;
    int unsigned w;
    w       = addr >> 2;
    e.write = wr;
    e.fault = (w >= DEPTH) || (wr && !lane_ok(be));
    e.rdata = '0;
    if (!e.fault) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[w][8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        e.rdata = model_mem[w];
      end
    end
    e.acc_cyc = cyc;
    e.exact   = exact;
    e.seq     = seq_n++;
    exp_q.push_back(e);
    acc_cnt++;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input bit exact);
    int n;
    n           = 0;
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wd;
    req_byte_en = be;
    @(negedge clock);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    check("req_accept", req_ready, 1'b1);
    if (req_ready) record_accept(wr, addr, wd, be, exact);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("outstanding_bound", 32'((acc_cnt - cons_cnt) <= FD), 1);
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            check("resp_unexpected", resp_valid, 1'b0);
          end else begin
            head_e = exp_q[0];
            if (head_e.seq != last_seq) begin
              last_seq = head_e.seq;
              if (head_e.exact) check("latency", cyc - head_e.acc_cyc, RL + 1);
              else check("latency_min", 32'((cyc - head_e.acc_cyc) >= RL + 1), 1);
            end
            check("resp_rdata", resp_rdata, head_e.rdata);
            check("resp_write", resp_write, head_e.write);
            check("resp_fault", resp_fault, head_e.fault);
            if (resp_ready) begin
              void'(exp_q.pop_front());
              cons_cnt++;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (toggle_mode) resp_ready = ~resp_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_acc;
    logic k_wr;
    logic [31:0] k_addr;

    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_write", resp_write, 1'b0);
    check("rst_resp_fault", resp_fault, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("ready_after_release", req_ready, 1'b1);
    resp_ready = 1'b1;

    issue(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b1);
    issue(1'b0, 32'h100, 32'h0, 4'b0000, 1'b1);
    wait_drain();

    issue(1'b1, 32'h100, 32'h000000AA, 4'b0001, 1'b0);
    issue(1'b1, 32'h100, 32'h55660000, 4'b1100, 1'b0);
    issue(1'b0, 32'h100, 32'h0, 4'b0000, 1'b0);
    wait_drain();

    issue(1'b1, 32'h20, 32'h11223344, 4'b1111, 1'b0);
    for (int k = 0; k < 8; k++) issue(1'b1, 32'h200 + 32'(4 * k), $urandom, 4'b1111, 1'b0);
    wait_drain();

    resp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_addr    = 32'h200 + 32'(4 * i);
      req_byte_en = 4'b0000;
      @(negedge clock);
      if (req_ready) begin
        record_accept(1'b0, req_addr, 32'h0, 4'b0000, 1'b0);
        n_acc++;
      end
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    check("stall_accept_count", n_acc, 4);
    @(negedge clock);
    check("stall_ready_low", req_ready, 1'b0);
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    @(negedge clock);
    check("ready_low_before_consume", req_ready, 1'b0);
    @(negedge clock);
    check("ready_after_consume", req_ready, 1'b1);
    @(posedge clock);
    #1;
    wait_drain();

    issue(1'b0, 32'h0001_0000, 32'h0, 4'b0000, 1'b0);
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0110, 1'b0);
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 4'b0000, 1'b0);
    issue(1'b0, 32'h103, 32'h0, 4'b0000, 1'b0);
    wait_drain();

    issue(1'b0, 32'h200, 32'h0, 4'b0000, 1'b0);
    issue(1'b0, 32'h204, 32'h0, 4'b0000, 1'b0);
    issue(1'b0, 32'h208, 32'h0, 4'b0000, 1'b0);
    reset = 1'b0;
    #1;
    check("midflight_resp_valid", resp_valid, 1'b0);
    check("midflight_req_ready", req_ready, 1'b0);
    exp_q.delete();
    acc_cnt  = 0;
    cons_cnt = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("ready_after_midflight", req_ready, 1'b1);
    repeat (8) begin
      @(negedge clock);
      check("no_stale_resp", resp_valid, 1'b0);
    end
    @(posedge clock);
    #1;
    issue(1'b0, 32'h100, 32'h0, 4'b0000, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 4'b0000, 1'b0);
    wait_drain();

    toggle_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      k_wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 8) == 8) k_addr = 32'h0004_0000 | 32'($urandom_range(0, 255));
      else k_addr = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      issue(k_wr, k_addr, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    wait_drain();
    toggle_mode = 1'b0;
    resp_ready  = 1'b1;
    for (int k = 0; k < 8; k++) issue(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'b0000, 1'b0);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
